// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle datapath sequencer with halt, memory wait states and retire counter; optional CTRL_SINGLE_STEP_EN adds a step input gating FETCH
module multicycle_controller #(
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic [5:0]       opcode,
  output logic [5:0]       ALUop,
  output logic [1:0]       PCControl,
  output logic             Call,
  output logic [1:0]       RegDst,
  output logic             ALUSrc1,
  output logic             ALUSrc2,
  output logic             RegWrite,
  output logic             SPWrite,
  output logic [1:0]       ZControl,
  output logic             MemToOut,
  output logic             PCUpdate,
  output logic             MemWrite,
  output logic             WriteDataSrc,
  output logic             SPUpdate,
  output logic [1:0]       ZControlSP,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  state_t           r_state, w_next;
  logic [5:0]       r_op;
  logic [3:0]       r_wait;
  logic             r_illegal;
  logic [CNT_W-1:0] r_count;
  logic w_r, w_i, w_ld, w_st, w_call, w_ret, w_push, w_pop, w_sp, w_mem;
  logic w_halt_in, w_legal_in, w_go;
  assign w_r        = r_op == 6'd0;
  assign w_i        = r_op == 6'd1;
  assign w_ld       = r_op == 6'd2;
  assign w_st       = r_op == 6'd3;
  assign w_call     = r_op == 6'd8;
  assign w_ret      = r_op == 6'd9;
  assign w_push     = r_op == 6'd10;
  assign w_pop      = r_op == 6'd11;
  assign w_sp       = w_call | w_ret | w_push | w_pop;
  assign w_mem      = w_ld | w_st | w_sp;
  assign w_halt_in  = opcode == 6'h3f;
  assign w_legal_in = opcode <= 6'd11;
`ifdef CTRL_SINGLE_STEP_EN
  assign w_go = step;
`else
  assign w_go = 1'b1;
`endif
  assign halted      = r_state == S_HALT;
  assign illegal     = r_illegal;
  assign instr_count = r_count;
  // State register, opcode latch, MEM wait countdown, sticky illegal flag and retire counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_op      <= '0;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op <= opcode;
      if (r_state == S_DECODE && !w_halt_in && !w_legal_in) r_illegal <= 1'b1;
      if (r_state == S_EXEC) r_wait <= 4'(MEM_WAIT);
      else if (r_state == S_MEM && r_wait != 4'd0) r_wait <= r_wait - 4'd1;
      if (r_state == S_WB) r_count <= r_count + CNT_W'(1);
    end
  end
  // Next-state selection; unknown opcodes and HALT park the machine until reset
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = w_go ? S_DECODE : S_FETCH;
      S_DECODE: w_next = (w_halt_in || !w_legal_in) ? S_HALT : S_EXEC;
      S_EXEC:   w_next = w_mem ? S_MEM : S_WB;
      S_MEM:    w_next = (r_wait == 4'd0) ? S_WB : S_MEM;
      S_WB:     w_next = S_FETCH;
      default:  w_next = S_HALT;
    endcase
  end
  // Strobe decode from (state, latched opcode); PC clear is forced while reset is held
  always_comb begin
    ALUop        = '0;
    PCControl    = rst ? 2'b10 : 2'b00;
    Call         = 1'b0;
    RegDst       = 2'b00;
    ALUSrc1      = 1'b0;
    ALUSrc2      = 1'b0;
    RegWrite     = 1'b0;
    SPWrite      = 1'b0;
    ZControl     = 2'b00;
    MemToOut     = 1'b0;
    PCUpdate     = 1'b0;
    MemWrite     = 1'b0;
    WriteDataSrc = 1'b0;
    SPUpdate     = 1'b0;
    ZControlSP   = 2'b00;
    if (!rst) begin
      case (r_state)
        S_EXEC: begin
          ZControl   = 2'b10;
          ALUop      = r_op;
          ALUSrc2    = w_i | w_ld | w_st;
          ALUSrc1    = w_sp;
          SPUpdate   = w_ret | w_pop;
          ZControlSP = w_sp ? 2'b10 : 2'b00;
        end
        S_MEM: begin
          ZControl     = 2'b01;
          MemWrite     = (w_st | w_push | w_call) && r_wait == 4'd0;
          WriteDataSrc = w_call;
          Call         = w_call;
        end
        S_WB: begin
          PCControl  = 2'b01;
          RegDst     = w_r ? 2'b10 : (w_i | w_ld | w_pop) ? 2'b01 : 2'b00;
          RegWrite   = w_r | w_i | w_ld | w_pop;
          MemToOut   = w_r | w_i;
          ZControl   = w_r ? 2'b01 : 2'b00;
          SPWrite    = w_sp;
          ZControlSP = w_sp ? 2'b01 : 2'b00;
          Call       = w_call;
          PCUpdate   = w_ret;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench for multicycle_controller with MEM_WAIT=3, CNT_W=4
module tb_multicycle_controller;
  localparam int MW = 3;
  localparam int ST_FETCH = 0, ST_DEC = 1, ST_EXEC = 2, ST_MEM = 3, ST_WB = 4, ST_HALT = 5;
  typedef struct packed {
    logic [5:0] aluop;
    logic [1:0] pcc;
    logic       call;
    logic [1:0] regdst;
    logic       src1, src2, regw, spw;
    logic [1:0] zc;
    logic       mto, pcu, mw, wds, spu;
    logic [1:0] zsp;
    logic       hlt, ill;
    logic [3:0] cnt;
  } exp_t;
  logic clk, rst;
  logic [5:0] opcode, ALUop;
  logic [1:0] PCControl, RegDst, ZControl, ZControlSP;
  logic Call, ALUSrc1, ALUSrc2, RegWrite, SPWrite, MemToOut, PCUpdate, MemWrite, WriteDataSrc, SPUpdate;
  logic halted, illegal;
  logic [3:0] instr_count;
  int checks = 0, errors = 0;
  logic [3:0] m_cnt;
  logic m_ill;
  exp_t q[$];
  string tq[$];
  multicycle_controller #(.MEM_WAIT(MW), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .ALUop(ALUop), .PCControl(PCControl), .Call(Call),
    .RegDst(RegDst), .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2), .RegWrite(RegWrite), .SPWrite(SPWrite),
    .ZControl(ZControl), .MemToOut(MemToOut), .PCUpdate(PCUpdate), .MemWrite(MemWrite),
    .WriteDataSrc(WriteDataSrc), .SPUpdate(SPUpdate), .ZControlSP(ZControlSP), .halted(halted),
    .illegal(illegal), .instr_count(instr_count));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic exp_t obs();
    return '{ALUop, PCControl, Call, RegDst, ALUSrc1, ALUSrc2, RegWrite, SPWrite, ZControl,
             MemToOut, PCUpdate, MemWrite, WriteDataSrc, SPUpdate, ZControlSP, halted, illegal, instr_count};
  endfunction
  function automatic exp_t reset_exp();
    exp_t e = '0;
    e.pcc = 2'b10;
    return e;
  endfunction
  function automatic exp_t model(int st, int op, bit fin);
    exp_t e = '0;
    bit sp = op >= 8 && op <= 11;
    e.cnt = m_cnt;
    e.ill = m_ill;
    if (st == ST_EXEC) begin
      e.zc = 2'b10;
      e.aluop = 6'(op);
      e.src2 = op >= 1 && op <= 3;
      if (sp) begin
        e.src1 = 1'b1;
        e.spu = op == 9 || op == 11;
        e.zsp = 2'b10;
      end
    end else if (st == ST_MEM) begin
      e.zc = 2'b01;
      e.mw = fin && (op == 3 || op == 10 || op == 8);
      e.wds = op == 8;
      e.call = op == 8;
    end else if (st == ST_WB) begin
      e.pcc = 2'b01;
      if (op == 0) begin e.regdst = 2'b10; e.regw = 1'b1; e.mto = 1'b1; e.zc = 2'b01; end
      if (op == 1) begin e.regdst = 2'b01; e.regw = 1'b1; e.mto = 1'b1; end
      if (op == 2 || op == 11) begin e.regdst = 2'b01; e.regw = 1'b1; end
      if (sp) begin e.spw = 1'b1; e.zsp = 2'b01; end
      e.call = op == 8;
      e.pcu = op == 9;
    end else if (st == ST_HALT) e.hlt = 1'b1;
    return e;
  endfunction
  task automatic chk(input string tag, input exp_t got, input exp_t want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask
  task automatic push(input exp_t e, input string tag);
    q.push_back(e);
    tq.push_back(tag);
  endtask
  task automatic ex(input int st, input int op, input bit fin, input string tag);
    push(model(st, op, fin), $sformatf("%s_op%0d_st%0d", tag, op, st));
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int op, input string tag);
    opcode = 6'(op);
    ex(ST_FETCH, op, 0, tag); tick();
    ex(ST_DEC, op, 0, tag); tick();
    if (op == 63 || op > 11) begin
      if (op != 63) m_ill = 1'b1;
      ex(ST_HALT, op, 0, tag);
      return;
    end
    ex(ST_EXEC, op, 0, tag); tick();
    if (op >= 2 && op != 4 && op != 5 && op != 6 && op != 7)
      for (int k = 0; k <= MW; k++) begin ex(ST_MEM, op, k == MW, tag); tick(); end
    ex(ST_WB, op, 0, tag); tick();
    m_cnt = m_cnt + 4'd1;
  endtask
  // Scoreboard: pop one expectation per cycle, compared away from the active edge
  always @(negedge clk) begin
    if (q.size() > 0) chk(tq.pop_front(), obs(), q.pop_front());
  end
  initial begin
    rst = 1'b1; opcode = '0; m_cnt = '0; m_ill = 1'b0;
    #2 push(reset_exp(), "reset_a");
    tick();
    tick(); push(reset_exp(), "reset_b");
    tick(); rst = 1'b0;
    run(0, "ralu");
    run(3, "st");
    run(8, "call");
    run(9, "ret");
    run(1, "ialu");
    run(2, "ld");
    run(10, "push");
    run(11, "pop");
    run(5, "br");
    opcode = 6'd3;
    ex(ST_FETCH, 3, 0, "st_abort"); tick();
    ex(ST_DEC, 3, 0, "st_abort"); tick();
    ex(ST_EXEC, 3, 0, "st_abort"); tick();
    ex(ST_MEM, 3, 0, "st_abort"); tick();
    #2 rst = 1'b1;
    #1 chk("async_reset", obs(), reset_exp());
    m_cnt = '0;
    push(reset_exp(), "abort_hold_a"); tick();
    push(reset_exp(), "abort_hold_b"); tick();
    rst = 1'b0;
    for (int n = 0; n < 16; n++) run(0, "wrap");
    run(48, "illegal");
    repeat (20) begin tick(); ex(ST_HALT, 48, 0, "halt_hold"); end
    tick(); rst = 1'b1; m_cnt = '0; m_ill = 1'b0;
    push(reset_exp(), "reset_c"); tick();
    rst = 1'b0;
    run(63, "halt");
    repeat (3) begin tick(); ex(ST_HALT, 63, 0, "halt_hold2"); end
    @(negedge clk); #1;
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
